// File: rtl/gate_bist_checker.sv
// BIST sequencer/checker for the basic gate set.
// Walks {a,b} through 00..11 and scores the seven gate outputs.
module gate_bist_checker #(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  input  logic [6:0]       gate_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       fail_vec,
  output logic [1:0]       first_fail_pat,
  output logic             first_fail_vld
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W+2:0] ERR_MAX = {3'b000, {ERR_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t        r_state;
  logic [1:0]    r_pat;
  logic [CW-1:0] r_cnt;

  logic             w_a;
  logic             w_b;
  logic [6:0]       w_exp;
  logic [6:0]       w_mism;
  logic [2:0]       w_pop;
  logic [ERR_W+2:0] w_sum;
  logic [ERR_W-1:0] w_err_nxt;

  always_comb begin
    w_a   = r_pat[1];
    w_b   = r_pat[0];
    w_exp = {~w_a, ~(w_a ^ w_b), w_a ^ w_b,
             ~(w_a | w_b), ~(w_a & w_b),
             w_a | w_b, w_a & w_b};
    w_mism = gate_y ^ w_exp;
    w_pop  = '0;
    for (int i = 0; i < 7; i++) begin
      w_pop = w_pop + {2'b00, w_mism[i]};
    end
    w_sum = {3'b000, err_count} + {{ERR_W{1'b0}}, w_pop};
    // Clamp so a badly broken gate bank cannot wrap back to zero
    w_err_nxt = (w_sum > ERR_MAX) ? {ERR_W{1'b1}}
                                  : w_sum[ERR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pat          <= '0;
      r_cnt          <= '0;
      a_o            <= 1'b0;
      b_o            <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      fail_vec       <= '0;
      first_fail_pat <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state        <= SETTLE;
            r_pat          <= '0;
            r_cnt          <= '0;
            a_o            <= 1'b0;
            b_o            <= 1'b0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            fail_vec       <= '0;
            first_fail_pat <= '0;
            first_fail_vld <= 1'b0;
          end
        end
        SETTLE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= CHECK;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CHECK: begin
          err_count <= w_err_nxt;
          fail_vec  <= fail_vec | w_mism;
          if ((|w_mism) && !first_fail_vld) begin
            first_fail_pat <= r_pat;
            first_fail_vld <= 1'b1;
          end
          if (r_pat == 2'd3) begin
            r_state <= DONE;
            a_o     <= 1'b0;
            b_o     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (w_err_nxt == '0);
          end else begin
            r_state      <= SETTLE;
            r_pat        <= r_pat + 2'd1;
            {a_o, b_o}   <= r_pat + 2'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
